// File: rtl/led_seq_pkg.sv
// Shared types and sizing helpers for the LED breathing sequencer.
//   seq_state_t : breathing FSM state encoding
//   idx_width   : bits needed to index N LEDs (at least 1)
//   cnt_width   : bits needed to hold a count 0..n (at least 1)
//   duty_max    : full-scale duty for a given PWM width
package led_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } seq_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    function automatic int duty_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/led_breathe_sequencer_tick_prescaler.sv
// Programmable tick prescaler.
//   clk      : clock
//   srst     : synchronous active-high reset (loads load_val)
//   load     : hold the counter at load_val (sequencer idle)
//   enable   : allow counting / tick generation
//   load_val : tick period minus 1, sampled on reset, load and reload only
//   tick     : combinational pulse while the counter sits at zero
module tick_prescaler #(
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] load_val,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] psc_reg;

    assign tick = enable && !load && (psc_reg == '0);

    always_ff @(posedge clk) begin
        if (srst) begin
            psc_reg <= load_val;
        end else if (load) begin
            psc_reg <= load_val;
        end else if (enable) begin
            if (psc_reg == '0) begin
                psc_reg <= load_val;
            end else begin
                psc_reg <= psc_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_breathe_sequencer.sv
// PWM "breathing" LED sequencer. Each LED ramps up, holds, ramps down and
// holds; in chase mode the sequence then moves to the next LED, in sync
// mode all LEDs breathe together.
//   WB_CLK     : fabric clock
//   WB_RST     : synchronous active-high reset
//   en         : run enable, 0 forces idle
//   sync_all   : 1 = all LEDs share one duty, 0 = chase
//   step_div   : tick period minus 1 in WB_CLK cycles
//   led        : registered active-high LED drive
//   active_idx : index of the LED currently breathing
//   cycle_done : one-cycle pulse on chase wrap, or every HOLD_LO exit in sync mode
module led_breathe_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_N      = 3,
    parameter int PWM_W      = 8,
    parameter int PRESCALE_W = 24,
    parameter int HOLD_TICKS = 64
) (
    input  logic                      WB_CLK,
    input  logic                      WB_RST,
    input  logic                      en,
    input  logic                      sync_all,
    input  logic [PRESCALE_W-1:0]     step_div,
    output logic [LED_N-1:0]          led,
    output logic [$clog2(LED_N)-1:0]  active_idx,
    output logic                      cycle_done
);

    localparam int IDX_W  = idx_width(LED_N);
    localparam int HOLD_W = cnt_width(HOLD_TICKS - 1);
    localparam logic [PWM_W-1:0]  DUTY_MAX  = PWM_W'(duty_max(PWM_W));
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LED_N - 1);

    seq_state_t         state_reg, state_next;
    logic [PWM_W-1:0]   duty_reg, duty_next;
    logic [PWM_W-1:0]   pwm_reg, pwm_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [LED_N-1:0]   led_reg, led_next;
    logic               cycle_done_reg, cycle_done_next;
    logic               tick;
    logic               hold_last;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (WB_CLK),
        .srst     (WB_RST),
        .load     (state_reg == IDLE),
        .enable   (en),
        .load_val (step_div),
        .tick     (tick)
    );

    // State register, including datapath counters and registered outputs.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state_reg      <= IDLE;
            duty_reg       <= '0;
            pwm_reg        <= '0;
            hold_reg       <= '0;
            idx_reg        <= '0;
            led_reg        <= '0;
            cycle_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            duty_reg       <= duty_next;
            pwm_reg        <= pwm_next;
            hold_reg       <= hold_next;
            idx_reg        <= idx_next;
            led_reg        <= led_next;
            cycle_done_reg <= cycle_done_next;
        end
    end

    assign hold_last = (hold_reg == HOLD_LAST);

    // Next-state logic. Ramp/hold progress only on a prescaler tick; the
    // idle exit and the en drop act immediately.
    always_comb begin
        state_next      = state_reg;
        duty_next       = duty_reg;
        hold_next       = hold_reg;
        idx_next        = idx_reg;
        cycle_done_next = 1'b0;
        pwm_next        = (state_reg == IDLE) ? pwm_reg : pwm_reg + 1'b1;

        if (!en) begin
            state_next = IDLE;
            duty_next  = '0;
            hold_next  = '0;
            idx_next   = '0;
            pwm_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = RAMP_UP;
                end
                RAMP_UP: begin
                    if (tick) begin
                        duty_next = duty_reg + 1'b1;
                        if (duty_reg == DUTY_MAX - 1'b1) begin
                            state_next = HOLD_HI;
                        end
                    end
                end
                HOLD_HI: begin
                    if (tick) begin
                        if (hold_last) begin
                            hold_next  = '0;
                            state_next = RAMP_DOWN;
                        end else begin
                            hold_next = hold_reg + 1'b1;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (tick) begin
                        duty_next = duty_reg - 1'b1;
                        if (duty_reg == PWM_W'(1)) begin
                            state_next = HOLD_LO;
                        end
                    end
                end
                HOLD_LO: begin
                    if (tick) begin
                        if (hold_last) begin
                            hold_next  = '0;
                            state_next = RAMP_UP;
                            // In sync mode the index stays put and every
                            // breath completion counts as a full cycle.
                            if (sync_all) begin
                                cycle_done_next = 1'b1;
                            end else if (idx_reg == IDX_LAST) begin
                                idx_next        = '0;
                                cycle_done_next = 1'b1;
                            end else begin
                                idx_next = idx_reg + 1'b1;
                            end
                        end else begin
                            hold_next = hold_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output logic: per-LED PWM compare against the current duty.
    generate
        for (genvar gi = 0; gi < LED_N; gi++) begin : g_led
            always_comb begin
                led_next[gi] = (sync_all || (idx_reg == IDX_W'(gi))) && (duty_reg > pwm_reg);
            end
        end
    endgenerate

    assign led        = led_reg;
    assign active_idx = idx_reg;
    assign cycle_done = cycle_done_reg;

endmodule

// File: tb/tb_led_breathe_sequencer.sv
module tb_led_breathe_sequencer;

    localparam int LED_N      = 3;
    localparam int PWM_W      = 4;
    localparam int PRESCALE_W = 24;
    localparam int HOLD       = 2;
    localparam int MAXV       = (1 << PWM_W) - 1;
    localparam int PERIOD     = 2 * MAXV + 2 * HOLD;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  en = 1'b1;
    logic                  sync_all = 1'b0;
    logic [PRESCALE_W-1:0] step_div = '0;
    logic [LED_N-1:0]      led;
    logic [1:0]            active_idx;
    logic                  cycle_done;

    always #5 clk = ~clk;

    led_breathe_sequencer #(
        .LED_N      (LED_N),
        .PWM_W      (PWM_W),
        .PRESCALE_W (PRESCALE_W),
        .HOLD_TICKS (HOLD)
    ) dut (
        .WB_CLK     (clk),
        .WB_RST     (rst),
        .en         (en),
        .sync_all   (sync_all),
        .step_div   (step_div),
        .led        (led),
        .active_idx (active_idx),
        .cycle_done (cycle_done)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model: position p counts ticks within one LED's breath (0..PERIOD-1);
    // duty is a piecewise function of p.
    int m_run = 0, m_p = 0, m_idx = 0, m_psc = 0, m_pwm = 0;
    int m_led = 0, m_cd = 0, m_led_duty = 0, m_led_ramp = 0, m_led_sync = 0;
    int cd_seen = 0, dc_total = 0, dc_high = 0, sync_viol = 0, chase_viol = 0;

    function automatic int duty_of(input int p);
        int d;
        if (p <= MAXV + HOLD) return (p < MAXV) ? p : MAXV;
        d = MAXV - (p - MAXV - HOLD);
        return (d < 0) ? 0 : d;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        int  d;
        int  nl;
        bit  tick;
        cyc++;
        d  = duty_of(m_p);
        nl = 0;
        for (int i = 0; i < LED_N; i++)
            if ((sync_all || i == m_idx) && d > m_pwm) nl |= (1 << i);
        m_led_duty = d;
        m_led_ramp = (m_p <= MAXV) ? 1 : 0;
        m_led_sync = sync_all ? 1 : 0;
        if (rst) begin
            m_led = 0; m_run = 0; m_p = 0; m_idx = 0; m_pwm = 0; m_cd = 0;
            m_psc = int'(step_div);
        end else begin
            m_led = nl;
            m_cd  = 0;
            if (!en) begin
                m_run = 0; m_p = 0; m_idx = 0; m_pwm = 0;
            end else if (m_run == 0) begin
                m_run = 1;
                m_psc = int'(step_div);
            end else begin
                tick  = (m_psc == 0);
                m_psc = tick ? int'(step_div) : m_psc - 1;
                m_pwm = (m_pwm + 1) % (MAXV + 1);
                if (tick) begin
                    m_p++;
                    if (m_p == PERIOD) begin
                        m_p = 0;
                        if (sync_all) m_cd = 1;
                        else if (m_idx == LED_N - 1) begin m_idx = 0; m_cd = 1; end
                        else m_idx++;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, 3 ns after the edge.
    always @(posedge clk) begin
        #3;
        check("led", int'(led), m_led);
        check("active_idx", int'(active_idx), m_idx);
        check("cycle_done", int'(cycle_done), m_cd);
        if (cycle_done) cd_seen++;
        if (m_led_sync == 1 && led != '0 && led != '1) sync_viol++;
        if (m_led_sync == 0 && $countones(led) > 1) chase_viol++;
        if (m_led_duty == 8 && m_led_ramp == 1 && m_idx == 0) begin
            dc_total++;
            if (led[0]) dc_high++;
        end
    end

    task automatic wait_model(input int want_idx, input int want_p, input int budget);
        int k = 0;
        while (!(m_run == 1 && m_idx == want_idx && m_p == want_p) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_model", (m_idx == want_idx && m_p == want_p) ? 1 : 0, 1);
    endtask

    task automatic wait_idx(input int want, input int budget, output int at);
        int k = 0;
        while (int'(active_idx) != want && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_idx", int'(active_idx), want);
        at = cyc;
    endtask

    task automatic wait_cd(input int budget, output int at);
        int k = 0;
        while (!cycle_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_cd", int'(cycle_done), 1);
        at = cyc;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int c1, c2, snap, snap2;

        // Reset held 3 clocks with en=1.
        repeat (3) @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_idx", int'(active_idx), 0);
        check("rst_cd", int'(cycle_done), 0);
        rst = 1'b0;
        snap = cd_seen;

        // Chase: LED period 34 clocks, one wrap per 102 clocks.
        repeat (34) @(negedge clk);
        check("chase_idx0", int'(active_idx), 0);
        @(negedge clk);
        check("chase_idx1", int'(active_idx), 1);
        repeat (34) @(negedge clk);
        check("chase_idx2", int'(active_idx), 2);
        repeat (34) @(negedge clk);
        check("chase_wrap_idx", int'(active_idx), 0);
        check("chase_wrap_cd", int'(cycle_done), 1);
        check("chase_cd_count1", cd_seen - snap, 1);
        repeat (102) @(negedge clk);
        check("chase_cd_count2", cd_seen - snap, 2);
        check("chase_onehot", chase_viol, 0);

        // Sync mode: identical LEDs, cycle_done every 34 clocks.
        sync_all = 1'b1;
        do_reset(2);
        snap = sync_viol;
        wait_cd(60, c1);
        @(negedge clk);
        wait_cd(60, c2);
        check("sync_cd_period", c2 - c1, 34);
        repeat (40) @(negedge clk);
        check("sync_identical", sync_viol - snap, 0);
        check("sync_idx", int'(active_idx), 0);

        // step_div=3: 136-clock LED period.
        sync_all = 1'b0;
        step_div = 24'd3;
        do_reset(2);
        wait_idx(1, 400, c1);
        wait_idx(2, 400, c2);
        check("div3_period", c2 - c1, 136);

        // Duty 8 held for 16 clocks -> led high 8 of 16.
        step_div = 24'd15;
        do_reset(2);
        snap  = dc_total;
        snap2 = dc_high;
        wait_model(0, 10, 400);
        check("duty8_total", dc_total - snap, 16);
        check("duty8_high", dc_high - snap2, 8);

        // en dropped during RAMP_DOWN at duty 7 on LED 1.
        step_div = 24'd0;
        do_reset(2);
        wait_model(1, MAXV + HOLD + (MAXV - 7), 200);
        check("model_duty7", duty_of(m_p), 7);
        en = 1'b0;
        @(negedge clk);
        check("endrop_idx", int'(active_idx), 0);
        @(negedge clk);
        check("endrop_led", int'(led), 0);
        check("endrop_cd", int'(cycle_done), 0);
        en = 1'b1;
        repeat (34) @(negedge clk);
        check("restart_idx0", int'(active_idx), 0);
        @(negedge clk);
        check("restart_idx1", int'(active_idx), 1);

        // Reset mid HOLD_HI on LED 2.
        wait_model(2, MAXV + 1, 200);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_led", int'(led), 0);
        check("midrst_idx", int'(active_idx), 0);
        check("midrst_cd", int'(cycle_done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
